// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and iteration-index schedule for the
// hyperbolic CORDIC square-root core.
package cordic_pkg;

  localparam int unsigned DATA_W   = 16;     // external operand / result width
  localparam int unsigned INT_W    = 18;     // internal x/y width (2 guard bits)
  localparam int unsigned FRAC_W   = 14;     // fractional bits, Q2.14
  localparam int unsigned QUARTER  = 4096;   // 0.25 in Q2.14
  localparam int unsigned GAIN_INV = 19784;  // 1/K_h in Q2.14
  localparam int unsigned IDX_W    = 4;      // shift index 1..15
  localparam int unsigned CNT_W    = 5;      // step counter, up to 17 steps
  localparam int unsigned WIDE_W   = INT_W + DATA_W;  // gain product width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    COMP = 2'd2
  } state_t;

  // Hyperbolic CORDIC needs indices 4 and 13 repeated for convergence:
  // steps 0..3 -> 1..4, steps 4..13 -> 4..13, steps 14.. -> 13..
  function automatic logic [IDX_W-1:0] step_index(input logic [CNT_W-1:0] step);
    if (step < CNT_W'(4))
      return IDX_W'(step + CNT_W'(1));
    else if (step <= CNT_W'(13))
      return IDX_W'(step);
    else
      return IDX_W'(step - CNT_W'(1));
  endfunction

  // Number of micro-rotations for a given highest index.
  function automatic int unsigned num_steps(input int unsigned iters);
    return iters + 1 + ((iters >= 13) ? 1 : 0);
  endfunction

endpackage

// File: rtl/cordic_hyp_step.sv
// Single hyperbolic CORDIC micro-rotation in vectoring mode (drives y to 0).
// Ports:
//   x, y          current signed Q4.14 vector
//   idx           shift index i for this step
//   x_next/y_next rotated vector
module cordic_hyp_step
  import cordic_pkg::*;
(
  input  logic signed [INT_W-1:0] x,
  input  logic signed [INT_W-1:0] y,
  input  logic        [IDX_W-1:0] idx,
  output logic signed [INT_W-1:0] x_next,
  output logic signed [INT_W-1:0] y_next
);

  logic signed [INT_W-1:0] x_sh;
  logic signed [INT_W-1:0] y_sh;

  assign x_sh = x >>> idx;
  assign y_sh = y >>> idx;

  // Rotate toward y = 0; truncating shifts, no rounding.
  always_comb begin
    x_next = x;
    y_next = y;
    if (y[INT_W-1]) begin
      x_next = x + y_sh;
      y_next = y + x_sh;
    end else begin
      x_next = x - y_sh;
      y_next = y - x_sh;
    end
  end

endmodule

// File: rtl/cordic_hyp_core.sv
// Iterative hyperbolic CORDIC computing sqrt(w) for a normalized Q2.14 operand.
// x0 = w + 0.25, y0 = w - 0.25, so x_final = K_h * sqrt(x0^2 - y0^2) = K_h * sqrt(w).
// Optional macro CORDIC_GAIN_COMP_EN: multiply the result by 1/K_h in COMP;
// when undefined the raw (gain-scaled) x is output.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   inp_valid            qualifies norm_inp / k_in (accepted only while in_ready)
//   norm_inp[15:0]       unsigned Q2.14 operand
//   k_in[2:0]            normalization shift, passed through
//   in_ready             high in IDLE
//   rot_out[15:0]        signed Q2.14 result
//   k_out[2:0]           k_in captured at accept
//   out_valid            one-cycle result strobe
module cordic_hyp_core
  import cordic_pkg::*;
#(
  parameter int unsigned ITERS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inp_valid,
  input  logic [DATA_W-1:0] norm_inp,
  input  logic [2:0]        k_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] rot_out,
  output logic [2:0]        k_out,
  output logic              out_valid
);

  localparam int unsigned STEPS = num_steps(ITERS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = WIDE_W'(-(2 ** (DATA_W - 1)));

  state_t state_q;
  state_t state_d;

  logic signed [INT_W-1:0] x_q;
  logic signed [INT_W-1:0] y_q;
  logic signed [INT_W-1:0] x_rot;
  logic signed [INT_W-1:0] y_rot;
  logic        [CNT_W-1:0] cnt_q;
  logic        [IDX_W-1:0] idx;
  logic                    accept;
  logic signed [WIDE_W-1:0] scaled;
  logic        [DATA_W-1:0] sat_val;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && inp_valid;
  assign idx      = step_index(cnt_q);

  cordic_hyp_step u_step (
    .x      (x_q),
    .y      (y_q),
    .idx    (idx),
    .x_next (x_rot),
    .y_next (y_rot)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inp_valid) state_d = ITER;
      ITER:    if (cnt_q == LAST_STEP) state_d = COMP;
      COMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Vector and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      x_q   <= INT_W'({{(INT_W - DATA_W){1'b0}}, norm_inp}) + INT_W'(QUARTER);
      y_q   <= INT_W'({{(INT_W - DATA_W){1'b0}}, norm_inp}) - INT_W'(QUARTER);
      cnt_q <= '0;
    end else if (state_q == ITER) begin
      x_q   <= x_rot;
      y_q   <= y_rot;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDE_W-1:0] GAIN_S  = WIDE_W'(GAIN_INV);
  localparam logic signed [WIDE_W-1:0] ROUND_S = WIDE_W'(2 ** (FRAC_W - 1));
  logic signed [WIDE_W-1:0] prod;

  // Gain compensation, round half up.
  assign prod   = WIDE_W'(x_q) * GAIN_S;
  assign scaled = (prod + ROUND_S) >>> FRAC_W;
`else
  assign scaled = WIDE_W'(x_q);
`endif

  // Saturate to the 16-bit signed result range.
  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    if (scaled > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (scaled < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
  end

  // Registered outputs; k_out captured at accept, rot_out at COMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_out   <= '0;
      k_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == COMP);
      if (accept)           k_out   <= k_in;
      if (state_q == COMP)  rot_out <= sat_val;
    end
  end

endmodule

// File: tb/tb_cordic_hyp_core.sv
module tb_cordic_hyp_core;

  localparam int ITERS = 12;
  localparam int LAT   = 14;
  localparam int TOL   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inp_valid;
  logic [15:0] norm_inp;
  logic [2:0]  k_in;
  logic        in_ready;
  logic [15:0] rot_out;
  logic [2:0]  k_out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_hyp_core #(.ITERS(ITERS)) dut (
    .clk       (clk),
    .reset     (reset),
    .inp_valid (inp_valid),
    .norm_inp  (norm_inp),
    .k_in      (k_in),
    .in_ready  (in_ready),
    .rot_out   (rot_out),
    .k_out     (k_out),
    .out_valid (out_valid)
  );

  // Reference: sqrt(w) in Q2.14, optionally scaled by the CORDIC gain.
  function automatic int model(input int w);
    real g;
    real r;
    g = 1.0;
    for (int i = 1; i <= ITERS; i++) begin
      real f;
      f = $sqrt(1.0 - 2.0 ** (-2.0 * i));
      g = g * f;
      if (i == 4 || i == 13) g = g * f;
    end
    r = 128.0 * $sqrt(real'(w));
`ifndef CORDIC_GAIN_COMP_EN
    r = r * g;
`endif
    return $rtoi(r + 0.5);
  endfunction

  function automatic int absdiff(input logic [15:0] a, input int b);
    int d;
    d = int'($signed(a)) - b;
    return (d < 0) ? -d : d;
  endfunction

  // One operation from IDLE: latency in edges after accept (LAT+27 = timeout),
  // captured outputs, and out_valid one edge after the pulse.
  task automatic run_op(input logic [15:0] w, input logic [2:0] k, output int lat,
                        output logic [15:0] rot, output logic [2:0] ko, output logic pulse2);
    @(negedge clk);
    norm_inp  = w;
    k_in      = k;
    inp_valid = 1'b1;
    @(posedge clk);
    #1 inp_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) lat = 41;
    rot = rot_out;
    ko  = k_out;
    @(posedge clk);
    #1 pulse2 = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; inp_valid = 1'b0; norm_inp = '0; k_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (rot_out !== 16'd0) begin errors++; $display("FAIL reset_rot_out got %0d want 0", rot_out); end
    checks++; if (k_out !== 3'd0) begin errors++; $display("FAIL reset_k_out got %0d want 0", k_out); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_directed();
    int ws[3];
    int ks[3];
    int spec[3];
    int lat;
    logic [15:0] rot;
    logic [2:0] ko;
    logic p2;
    ws = '{4096, 8192, 16383};
    ks = '{2, 5, 7};
`ifdef CORDIC_GAIN_COMP_EN
    spec = '{8192, 11585, 16384};
`else
    spec = '{6785, 9594, 13569};
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(16'(ws[i]), 3'(ks[i]), lat, rot, ko, p2);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir_latency w=%0d got %0d want %0d", ws[i], lat, LAT); end
      checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL dir_pulse_width w=%0d out_valid after pulse got %b want 0", ws[i], p2); end
      checks++; if (ko !== 3'(ks[i])) begin errors++; $display("FAIL dir_k_out w=%0d got %0d want %0d", ws[i], ko, ks[i]); end
      checks++; if (absdiff(rot, spec[i]) > TOL) begin errors++; $display("FAIL dir_rot_spec w=%0d got %0d want %0d+-%0d", ws[i], $signed(rot), spec[i], TOL); end
      checks++; if (absdiff(rot, model(ws[i])) > TOL) begin errors++; $display("FAIL dir_rot_model w=%0d got %0d want %0d+-%0d", ws[i], $signed(rot), model(ws[i]), TOL); end
    end
  endtask

  task automatic test_out_of_range();
    int ws[6];
    int lat;
    logic [15:0] rot;
    logic [2:0] ko;
    logic p2;
    ws = '{0, 100, 4095, 16384, 40000, 65535};
    for (int i = 0; i < 6; i++) begin
      run_op(16'(ws[i]), 3'(i), lat, rot, ko, p2);
      checks++; if (lat !== LAT || p2 !== 1'b0 || ko !== 3'(i)) begin
        errors++;
        $display("FAIL oor_timing w=%0d latency %0d pulse2 %b k %0d want %0d 0 %0d", ws[i], lat, p2, ko, LAT, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int q_w[$];
    int q_k[$];
    logic exp_v;
    @(negedge clk);
    inp_valid = 1'b1;
    norm_inp  = 16'($urandom_range(4096, 16383));
    k_in      = 3'($urandom);
    for (int e = 0; e < 75; e++) begin
      if (e % 15 == 0) begin
        q_w.push_back(int'(norm_inp));
        q_k.push_back(int'(k_in));
      end
      @(posedge clk);
      #1;
      norm_inp = 16'($urandom_range(4096, 16383));
      k_in     = 3'($urandom);
      exp_v    = (e % 15 == 14);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid edge %0d got %b want %b", e, out_valid, exp_v); end
      checks++; if (in_ready !== exp_v) begin errors++; $display("FAIL b2b_in_ready edge %0d got %b want %b", e, in_ready, exp_v); end
      if (exp_v && q_w.size() > 0) begin
        int w;
        int k;
        w = q_w.pop_front();
        k = q_k.pop_front();
        checks++; if (absdiff(rot_out, model(w)) > TOL || k_out !== 3'(k)) begin
          errors++;
          $display("FAIL b2b_result w=%0d rot %0d k %0d want %0d+-%0d k %0d", w, $signed(rot_out), k_out, model(w), TOL, k);
        end
      end
    end
    inp_valid = 1'b0;
    checks++; if (q_w.size() != 0) begin errors++; $display("FAIL b2b_result_count leftover %0d want 0", q_w.size()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [15:0] rot;
    logic [2:0] ko;
    logic p2;
    @(negedge clk);
    norm_inp = 16'd8192; k_in = 3'd6; inp_valid = 1'b1;
    @(posedge clk);
    #1 inp_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || rot_out !== 16'd0 || k_out !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs valid %b rot %0d k %0d ready %b want 0 0 0 1", out_valid, rot_out, k_out, in_ready);
    end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || rot_out !== 16'd0) begin
      errors++;
      $display("FAIL midreset_hold valid %b rot %0d want 0 0", out_valid, rot_out);
    end
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_pulse got %0d pulses want 0", seen); end
    run_op(16'd8192, 3'd1, lat, rot, ko, p2);
    checks++; if (lat !== LAT || absdiff(rot, model(8192)) > TOL || ko !== 3'd1) begin
      errors++;
      $display("FAIL midreset_fresh latency %0d rot %0d k %0d want %0d %0d+-%0d 1", lat, $signed(rot), ko, LAT, model(8192), TOL);
    end
  endtask

  task automatic test_random();
    int lat;
    int w;
    logic [2:0] k;
    logic [15:0] rot;
    logic [2:0] ko;
    logic p2;
    for (int s = 0; s < 1000; s++) begin
      w = int'($urandom_range(4096, 16383));
      k = 3'($urandom);
      run_op(16'(w), k, lat, rot, ko, p2);
      checks++; if (lat !== LAT || p2 !== 1'b0 || ko !== k || absdiff(rot, model(w)) > TOL) begin
        errors++;
        $display("FAIL rand_sample w=%0d latency %0d pulse2 %b k %0d rot %0d want %0d 0 %0d %0d+-%0d",
                 w, lat, p2, ko, $signed(rot), LAT, k, model(w), TOL);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_hyp_core.md
CORDIC_HYP_CORE -- requirements
Module: cordic_hyp_core

Interface
REQ-001 Parameter ITERS, default 12, meaning the highest hyperbolic iteration index (legal range 4..15).
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  is the asynchronous, active-high reset.
REQ-004 Port inp_valid  input  1  qualifies norm_inp and k_in.
REQ-005 Port norm_inp  input  16  is the normalized operand w: unsigned Q2.14, legal range 4096..16383 (0.25 to just under 1.0).
REQ-006 Port k_in  input  3  is the normalization shift from the upstream stage, carried to the output unchanged.
REQ-007 Port in_ready  output  1  is high only in IDLE and is decoded from the state register.
REQ-008 Port rot_out  output  16  is the signed Q2.14 approximation of sqrt(w), feeding the output scaling stage.
REQ-009 Port k_out  output  3  is k_in as captured at accept.
REQ-010 Port out_valid  output  1  is a one-cycle pulse marking rot_out and k_out valid.

Function
REQ-011 Accept happens at a rising edge where in_ready=1 and inp_valid=1; inp_valid is ignored at every other edge.
REQ-012 At accept: x <= w+4096, y <= w-4096 (signed, 18-bit internal, 2 guard bits), k_out <= k_in, step counter <= 0, state IDLE->ITER.
REQ-013 Iteration index sequence is 1,2,3,4,4,5,...,ITERS, with index 13 also repeated when ITERS>=13; STEPS = ITERS + number of repeats (13 for ITERS=12).
REQ-014 Per ITER edge with index i: if y<0 then x<=x+(y>>>i), y<=y+(x>>>i); else x<=x-(y>>>i), y<=y-(x>>>i); arithmetic shifts, no rounding.
REQ-015 After the STEPS-th ITER edge, state becomes COMP.
REQ-016 COMP edge: rot_out <= compensated x (see Configuration), out_valid <= 1, state COMP->IDLE.
REQ-017 Latency: out_valid is high in the cycle following the (STEPS+1)-th edge after accept (14 edges for ITERS=12); with the IDLE return, throughput is one operation per STEPS+2 cycles.
REQ-018 out_valid is 0 in every other cycle; rot_out and k_out hold their values until the next COMP edge.
REQ-019 Conversion of x to rot_out saturates to 32767 and -32768 and never wraps.
REQ-020 Operands outside 4096..16383 are processed with identical timing; the numeric result is unspecified, but no lock-up and no change in state sequence is allowed.

Reset
REQ-021 While reset=1: state=IDLE, x=y=0, counter=0, rot_out=0, k_out=0, out_valid=0, in_ready=1.
REQ-022 Reset asserted mid-operation aborts the operation with no out_valid pulse; the first accept after reset release starts a fresh computation.

Configuration
REQ-023 Macro CORDIC_GAIN_COMP_EN defined: in COMP, rot_out = round-half-up((x * 19784) >> 14), saturated; 19784 is 1/K_h (about 1.2075) in Q2.14.
REQ-024 Macro CORDIC_GAIN_COMP_EN undefined: in COMP, rot_out = x saturated to 16 bits (about 0.8282*sqrt(w)), no multiplier; latency is the same.

Structure
REQ-025 Package cordic_pkg holds DATA_W=16, INT_W=18, FRAC_W=14, QUARTER=4096, GAIN_INV=19784, the state enum (IDLE, ITER, COMP) and the function giving the index for a step number.
REQ-026 One combinational sub-module, cordic_hyp_step, implements a single micro-rotation (x, y, i -> x', y'); the core instantiates it once and iterates.

Verification
REQ-027 CORDIC_GAIN_COMP_EN, norm_inp=4096, k_in=2 -> after 14 edges out_valid=1 for one cycle, rot_out=8192±8, k_out=2.
REQ-028 CORDIC_GAIN_COMP_EN, norm_inp=8192 -> rot_out=11585±8; norm_inp=16383 -> rot_out=16384±8.
REQ-029 Macro undefined, norm_inp=4096 -> rot_out=6785±8 with the same 14-edge latency.
REQ-030 inp_valid held high continuously with changing data -> only values present at edges where in_ready=1 are accepted; one result per 15 cycles; no extra pulses.
REQ-031 Reset pulsed at iteration 6 -> no out_valid pulse, all outputs 0; a subsequent accept of 8192 yields 11585±8.
REQ-032 Random norm_inp in 4096..16383 (1000 samples) -> |rot_out - round(16384*sqrt(w/16384))| <= 8 for every sample.
